bar_graph_pwm: RTL and testbench

Downstream stage of the Wishbone bar-graph register; sits between the register's 8-bit bar_graph output and the physical LED pins.
Renders each bit as a PWM-dimmed LED at a global brightness.
Each LED's duty cycle ramps linearly toward its target, one step per PWM period, so bitmap changes fade instead of snapping.
Pure fabric block; no bus interface. Brightness comes from a neighbouring register or is tied off.

---
 rtl/bar_graph_pwm.sv | 108 ++++++++++
 tb/tb_bar_graph_pwm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_graph_pwm.sv
// PWM LED bar-graph driver with linear per-period fading toward brightness-scaled targets.
// Optional gamma-2.0 brightness map when BAR_GRAPH_PWM_GAMMA_EN is defined.
module bar_graph_pwm #(
    parameter int PRESCALE  = 64,
    parameter int PWM_WIDTH = 8,
    parameter int FADE_STEP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           level_in,
    input  logic [PWM_WIDTH-1:0] brightness,
    input  logic                 enable,
    output logic [7:0]           led_out,
    output logic                 period_start,
    output logic                 fading
);

    localparam int                   PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]      PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PWM_WIDTH:0]   STEP    = (PWM_WIDTH+1)'(FADE_STEP);

    logic [PS_W-1:0]      presc;
    logic                 tick;
    logic                 boundary;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [PWM_WIDTH-1:0] bright_eff;
    logic [PWM_WIDTH-1:0] duty     [8];
    logic [PWM_WIDTH-1:0] target   [8];
    logic [PWM_WIDTH-1:0] duty_nxt [8];
    logic [7:0]           led_raw;
    logic                 fade_raw;

    assign tick     = (presc == PS_LAST);
    assign boundary = tick && (pwm_cnt == CNT_MAX);

`ifdef BAR_GRAPH_PWM_GAMMA_EN
    logic [PWM_WIDTH-1:0] sq_hi;
    logic [PWM_WIDTH-1:0] sq_unused_lo;

    assign {sq_hi, sq_unused_lo} = brightness * brightness;

    // Full scale is kept exact so "all-ones" still means constantly on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bright_eff <= '0;
        end else begin
            bright_eff <= (brightness == CNT_MAX) ? CNT_MAX : sq_hi;
        end
    end
`else
    assign bright_eff = brightness;
`endif

    // Step sizes are compared against the remaining distance, so no wrap or underflow.
    always_comb begin
        led_raw  = '0;
        fade_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            duty_nxt[i] = duty[i];
            if (duty[i] < target[i]) begin
                if ({1'b0, target[i] - duty[i]} <= STEP) begin
                    duty_nxt[i] = target[i];
                end else begin
                    duty_nxt[i] = duty[i] + STEP[PWM_WIDTH-1:0];
                end
            end else if (duty[i] > target[i]) begin
                if ({1'b0, duty[i] - target[i]} <= STEP) begin
                    duty_nxt[i] = target[i];
                end else begin
                    duty_nxt[i] = duty[i] - STEP[PWM_WIDTH-1:0];
                end
            end
            led_raw[i] = (pwm_cnt < duty[i]) || (duty[i] == CNT_MAX);
            fade_raw   = fade_raw | (duty[i] != target[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            led_out      <= '0;
            period_start <= 1'b0;
            fading       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                duty[i]   <= '0;
                target[i] <= '0;
            end
        end else begin
            presc <= tick ? '0 : presc + PS_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
            end
            period_start <= boundary;
            // Duties step toward the previous target while the new one is captured.
            if (boundary) begin
                for (int i = 0; i < 8; i++) begin
                    duty[i]   <= duty_nxt[i];
                    target[i] <= (enable && level_in[i]) ? bright_eff : '0;
                end
            end
            led_out <= led_raw;
            fading  <= fade_raw;
        end
    end

endmodule

// File: tb/tb_bar_graph_pwm.sv
// Directed bench: dut_a (PRESCALE=1, FADE_STEP=255) and dut_b (PRESCALE=2, FADE_STEP=4) share inputs.
module tb_bar_graph_pwm;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] level_in;
    logic [7:0] brightness;
    logic [7:0] led_a, led_b;
    logic       ps_a, ps_b, fad_a, fad_b;
    int         vectors;
    int         miscompares;

    bar_graph_pwm #(.PRESCALE(1), .PWM_WIDTH(8), .FADE_STEP(255)) dut_a (
        .clk(clk), .reset(reset), .level_in(level_in), .brightness(brightness),
        .enable(enable), .led_out(led_a), .period_start(ps_a), .fading(fad_a)
    );

    bar_graph_pwm #(.PRESCALE(2), .PWM_WIDTH(8), .FADE_STEP(4)) dut_b (
        .clk(clk), .reset(reset), .level_in(level_in), .brightness(brightness),
        .enable(enable), .led_out(led_b), .period_start(ps_b), .fading(fad_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge where the cycle count after release starts (cycle 0).
    task automatic apply_reset(input logic [7:0] br, input logic [7:0] lv, input logic en);
        reset      = 1'b0;
        brightness = br;
        level_in   = lv;
        enable     = en;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        step(2);
        vectors += 6;
        if (led_a !== 8'h00) begin miscompares++; $display("FAIL reset_led_a: got %h need 00", led_a); end
        if (led_b !== 8'h00) begin miscompares++; $display("FAIL reset_led_b: got %h need 00", led_b); end
        if (ps_a !== 1'b0)   begin miscompares++; $display("FAIL reset_ps_a: got %b need 0", ps_a); end
        if (ps_b !== 1'b0)   begin miscompares++; $display("FAIL reset_ps_b: got %b need 0", ps_b); end
        if (fad_a !== 1'b0)  begin miscompares++; $display("FAIL reset_fad_a: got %b need 0", fad_a); end
        if (fad_b !== 1'b0)  begin miscompares++; $display("FAIL reset_fad_b: got %b need 0", fad_b); end
    endtask

    task automatic test_full_on;
        int bad_led, bad_fad;
        apply_reset(8'hFF, 8'h81, 1'b1);
        step(255);
        vectors++;
        if (ps_a !== 1'b0) begin miscompares++; $display("FAIL full_ps255: got %b need 0", ps_a); end
        step(1);
        vectors += 2;
        if (ps_a !== 1'b1)  begin miscompares++; $display("FAIL full_ps256: got %b need 1", ps_a); end
        if (fad_a !== 1'b0) begin miscompares++; $display("FAIL full_fad256: got %b need 0", fad_a); end
        step(1);
        vectors++;
        if (fad_a !== 1'b1) begin miscompares++; $display("FAIL full_fad257: got %b need 1", fad_a); end
        step(255);
        vectors += 2;
        if (ps_a !== 1'b1)   begin miscompares++; $display("FAIL full_ps512: got %b need 1", ps_a); end
        if (led_a !== 8'h00) begin miscompares++; $display("FAIL full_led512: got %h need 00", led_a); end
        bad_led = 0;
        bad_fad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (led_a !== 8'h81) bad_led++;
            if (fad_a !== 1'b0) bad_fad++;
        end
        vectors += 2;
        if (bad_led != 0) begin miscompares++; $display("FAIL full_led_const: %0d off clocks, need 0", bad_led); end
        if (bad_fad != 0) begin miscompares++; $display("FAIL full_fad_settled: %0d fading clocks, need 0", bad_fad); end
    endtask

    task automatic test_duty_quarter;
        int hi, psn, other;
        apply_reset(8'h40, 8'h01, 1'b1);
        step(512);
        hi = 0; psn = 0; other = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (led_a[0] === 1'b1) hi++;
            if (ps_a === 1'b1) psn++;
            if (led_a[7:1] !== 7'd0) other++;
        end
        vectors += 4;
        if (hi != 64)       begin miscompares++; $display("FAIL quarter_high: got %0d need 64", hi); end
        if (psn != 1)       begin miscompares++; $display("FAIL quarter_ps_count: got %0d need 1", psn); end
        if (ps_a !== 1'b1)  begin miscompares++; $display("FAIL quarter_ps768: got %b need 1", ps_a); end
        if (other != 0)     begin miscompares++; $display("FAIL quarter_other_bits: got %0d need 0", other); end
    endtask

    task automatic test_fade;
        int exp_up[6]  = '{0, 8, 16, 24, 32, 32};
        int fad_up[6]  = '{1, 1, 1, 1, 0, 0};
        int exp_dn[6]  = '{32, 32, 24, 16, 8, 0};
        int fad_dn[6]  = '{0, 1, 1, 1, 1, 0};
        int hi;
        apply_reset(8'h10, 8'h00, 1'b1);
        step(600);
        level_in = 8'h02;
        step(424);
        vectors += 2;
        if (ps_b !== 1'b1)  begin miscompares++; $display("FAIL fade_ps1024: got %b need 1", ps_b); end
        if (fad_b !== 1'b0) begin miscompares++; $display("FAIL fade_fad1024: got %b need 0", fad_b); end
        for (int p = 0; p < 6; p++) begin
            hi = 0;
            for (int i = 0; i < 512; i++) begin
                step(1);
                if (led_b[1] === 1'b1) hi++;
            end
            vectors += 2;
            if (hi != exp_up[p]) begin miscompares++; $display("FAIL fade_up_p%0d: high %0d need %0d", p, hi, exp_up[p]); end
            if (fad_b !== fad_up[p][0]) begin miscompares++; $display("FAIL fade_up_fad_p%0d: got %b need %0d", p, fad_b, fad_up[p]); end
        end
        level_in = 8'h00;
        for (int p = 0; p < 6; p++) begin
            hi = 0;
            for (int i = 0; i < 512; i++) begin
                step(1);
                if (led_b[1] === 1'b1) hi++;
            end
            vectors += 2;
            if (hi != exp_dn[p]) begin miscompares++; $display("FAIL fade_dn_p%0d: high %0d need %0d", p, hi, exp_dn[p]); end
            if (fad_b !== fad_dn[p][0]) begin miscompares++; $display("FAIL fade_dn_fad_p%0d: got %b need %0d", p, fad_b, fad_dn[p]); end
        end
    endtask

    task automatic test_glitch;
        int bad_led, bad_fad;
        apply_reset(8'hFF, 8'h00, 1'b1);
        step(100);
        level_in = 8'hFF;
        step(50);
        level_in = 8'h00;
        bad_led = 0;
        bad_fad = 0;
        for (int i = 0; i < 700; i++) begin
            step(1);
            if (led_a !== 8'h00) bad_led++;
            if (fad_a !== 1'b0) bad_fad++;
        end
        vectors += 2;
        if (bad_led != 0) begin miscompares++; $display("FAIL glitch_led: %0d lit clocks, need 0", bad_led); end
        if (bad_fad != 0) begin miscompares++; $display("FAIL glitch_fad: %0d fading clocks, need 0", bad_fad); end
    endtask

    task automatic test_enable_off;
        apply_reset(8'hFF, 8'h81, 1'b1);
        step(600);
        enable = 1'b0;
        step(170);
        vectors++;
        if (fad_a !== 1'b1) begin miscompares++; $display("FAIL en_fad770: got %b need 1", fad_a); end
        step(230);
        vectors++;
        if (led_a !== 8'h81) begin miscompares++; $display("FAIL en_led1000: got %h need 81", led_a); end
        step(25);
        vectors += 2;
        if (led_a !== 8'h00) begin miscompares++; $display("FAIL en_led1025: got %h need 00", led_a); end
        if (fad_a !== 1'b0)  begin miscompares++; $display("FAIL en_fad1025: got %b need 0", fad_a); end
    endtask

    task automatic test_async_reset;
        int hi0, hi1;
        apply_reset(8'h40, 8'h08, 1'b1);
        step(4620);
        vectors += 2;
        if (led_b !== 8'h08) begin miscompares++; $display("FAIL ar_led_pre: got %h need 08", led_b); end
        if (fad_b !== 1'b1)  begin miscompares++; $display("FAIL ar_fad_pre: got %b need 1", fad_b); end
        #2 reset = 1'b0;
        #1;
        vectors += 3;
        if (led_b !== 8'h00) begin miscompares++; $display("FAIL ar_led_now: got %h need 00", led_b); end
        if (ps_b !== 1'b0)   begin miscompares++; $display("FAIL ar_ps_now: got %b need 0", ps_b); end
        if (fad_b !== 1'b0)  begin miscompares++; $display("FAIL ar_fad_now: got %b need 0", fad_b); end
        step(2);
        reset = 1'b1;
        step(511);
        vectors++;
        if (ps_b !== 1'b0) begin miscompares++; $display("FAIL ar_ps511: got %b need 0", ps_b); end
        step(1);
        vectors++;
        if (ps_b !== 1'b1) begin miscompares++; $display("FAIL ar_ps512: got %b need 1", ps_b); end
        hi0 = 0;
        hi1 = 0;
        for (int i = 0; i < 512; i++) begin
            step(1);
            if (led_b[3] === 1'b1) hi0++;
        end
        for (int i = 0; i < 512; i++) begin
            step(1);
            if (led_b[3] === 1'b1) hi1++;
        end
        vectors += 2;
        if (hi0 != 0) begin miscompares++; $display("FAIL ar_restart_p0: high %0d need 0", hi0); end
        if (hi1 != 8) begin miscompares++; $display("FAIL ar_restart_p1: high %0d need 8", hi1); end
    endtask

`ifdef BAR_GRAPH_PWM_GAMMA_EN
    task automatic test_gamma;
        int hi;
        apply_reset(8'h80, 8'h01, 1'b1);
        step(512);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (led_a[0] === 1'b1) hi++;
        end
        vectors++;
        if (hi != 64) begin miscompares++; $display("FAIL gamma_half: high %0d need 64", hi); end
        apply_reset(8'hFF, 8'h01, 1'b1);
        step(512);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (led_a[0] === 1'b1) hi++;
        end
        vectors++;
        if (hi != 256) begin miscompares++; $display("FAIL gamma_full: high %0d need 256", hi); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        level_in    = 8'h00;
        brightness  = 8'h00;
        #2 reset = 1'b0;
        test_reset();
        test_full_on();
        test_duty_quarter();
        test_fade();
        test_glitch();
        test_enable_off();
        test_async_reset();
`ifdef BAR_GRAPH_PWM_GAMMA_EN
        test_gamma();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
